// File: rtl/nf10_upb_packet_fifo_writer.sv
// AXI4-Stream slave feeding the write side of a commit/revert packet FIFO.
// A packet that hits FIFO full or exceeds MAX_PKT_BYTES is dropped whole; any beats already written are reverted.
module nf10_upb_packet_fifo_writer #(
  parameter int DATA_WIDTH     = 256,
  parameter int KEEP_WIDTH     = 32,
  parameter int METADATA_WIDTH = 16,
  parameter int MAX_PKT_BYTES  = 16383
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [KEEP_WIDTH-1:0]     S_AXIS_TKEEP,
  input  logic                      S_AXIS_TVALID,
  input  logic                      S_AXIS_TLAST,
  output logic                      S_AXIS_TREADY,
  input  logic                      FIFO_FULL,
  output logic [DATA_WIDTH-1:0]     FIFO_DI,
  output logic [METADATA_WIDTH-1:0] FIFO_MI,
  output logic                      FIFO_WREN,
  output logic                      FIFO_COMMIT,
  output logic                      FIFO_REVERT,
  output logic [31:0]               PKT_COUNT,
  output logic [31:0]               DROP_COUNT
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DROP} state_t;

  state_t                    state_q, state_d;
  logic [METADATA_WIDTH-1:0] len_acc_q, len_acc_d;
  logic [31:0]               pkt_count_q, pkt_count_d;
  logic [31:0]               drop_count_q, drop_count_d;

  logic [METADATA_WIDTH:0]   nbytes;
  logic [METADATA_WIDTH:0]   len_next;
  logic                      beat;
  logic                      writable;
  logic                      oversize;
  logic                      blocked;

  always_comb begin
    nbytes = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      nbytes = nbytes + {{METADATA_WIDTH{1'b0}}, S_AXIS_TKEEP[i]};
    end
  end

  // One extra bit keeps the running length from wrapping before the limit compare.
  assign len_next = {1'b0, len_acc_q} + nbytes;
  assign oversize = len_next > (METADATA_WIDTH + 1)'(MAX_PKT_BYTES);
  assign beat     = S_AXIS_TVALID;
  assign writable = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign blocked  = FIFO_FULL || oversize;

  assign S_AXIS_TREADY = 1'b1;
  assign FIFO_DI       = S_AXIS_TDATA;
  assign FIFO_MI       = len_next[METADATA_WIDTH-1:0];
  assign FIFO_WREN     = beat && writable && !blocked && !RST;
  assign FIFO_COMMIT   = FIFO_WREN && S_AXIS_TLAST;
  assign FIFO_REVERT   = beat && (state_q == ST_ACTIVE) && blocked && !RST;
  assign PKT_COUNT     = pkt_count_q;
  assign DROP_COUNT    = drop_count_q;

  always_comb begin
    state_d      = state_q;
    len_acc_d    = len_acc_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    if (beat) begin
      unique case (state_q)
        ST_IDLE, ST_ACTIVE: begin
          if (blocked) begin
            drop_count_d = drop_count_q + 32'd1;
            len_acc_d    = '0;
            state_d      = S_AXIS_TLAST ? ST_IDLE : ST_DROP;
          end else if (S_AXIS_TLAST) begin
            pkt_count_d = pkt_count_q + 32'd1;
            len_acc_d   = '0;
            state_d     = ST_IDLE;
          end else begin
            len_acc_d = len_next[METADATA_WIDTH-1:0];
            state_d   = ST_ACTIVE;
          end
        end
        ST_DROP: begin
          if (S_AXIS_TLAST) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      len_acc_q    <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_acc_q    <= len_acc_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: doc/nf10_upb_packet_fifo_writer.md
Name: nf10_upb_packet_fifo_writer

Overview:
- AXI4-Stream slave front end that feeds the write side of the team's commit/revert packet FIFO.
- Converts the stream into FIFO write controls (WREN, COMMIT, REVERT), DI, and per-packet metadata MI holding the packet byte length.
- Drops a packet in whole when the FIFO fills mid-packet or the packet exceeds a size limit. Beats already written for that packet are reverted.
- Never back-pressures: TREADY is constantly 1. Counts forwarded and dropped packets.

Parameters:
- DATA_WIDTH, 256, stream/FIFO data width in bits (multiple of 8).
- KEEP_WIDTH, 32, DATA_WIDTH/8.
- METADATA_WIDTH, 16, width of MI; carries the byte length.
- MAX_PKT_BYTES, 16383, packets longer than this are dropped; must be < 2^METADATA_WIDTH.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- S_AXIS_TDATA  in  DATA_WIDTH  stream data.
- S_AXIS_TKEEP  in  KEEP_WIDTH  byte enables; contiguous from bit 0 on the last beat, all ones otherwise.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TLAST  in  1  last beat of packet.
- S_AXIS_TREADY  out  1  constant 1.
- FIFO_FULL  in  1  FULL from the FIFO (combinational, same cycle).
- FIFO_DI  out  DATA_WIDTH  equals S_AXIS_TDATA.
- FIFO_MI  out  METADATA_WIDTH  packet byte length; valid when FIFO_COMMIT=1.
- FIFO_WREN  out  1  write beat.
- FIFO_COMMIT  out  1  beat is end of packet; store metadata.
- FIFO_REVERT  out  1  discard uncommitted beats.
- PKT_COUNT  out  32  committed packets.
- DROP_COUNT  out  32  dropped packets.

Behaviour:
- All FIFO_* controls are combinational from the stream inputs and registered state: zero latency. Only state, the length accumulator and the counters are registered.
- States:
  - IDLE: expecting first beat of a packet.
  - ACTIVE: at least one beat of the current packet written, not yet committed.
  - DROP: discarding beats until TLAST.
- Definitions:
  - beat = S_AXIS_TVALID.
  - nbytes = popcount(S_AXIS_TKEEP).
  - len_next = len_acc + nbytes, computed METADATA_WIDTH+1 bits wide so it never wraps.
  - oversize = len_next > MAX_PKT_BYTES.
- FIFO_WREN = beat & (IDLE|ACTIVE) & !FIFO_FULL & !oversize & !RST.
- FIFO_COMMIT = FIFO_WREN & TLAST.
- FIFO_MI = len_next[METADATA_WIDTH-1:0].
- FIFO_REVERT = beat & ACTIVE & (FIFO_FULL | oversize) & !RST.
- FIFO_REVERT and FIFO_WREN/FIFO_COMMIT are never asserted in the same cycle.
- Transitions, all on beat:
  - IDLE, write & !TLAST -> ACTIVE; len_acc <= nbytes.
  - IDLE, write & TLAST -> IDLE; PKT_COUNT += 1; len_acc <= 0.
  - IDLE, FULL or oversize -> DROP, or IDLE if TLAST. No revert (nothing written). DROP_COUNT += 1.
  - ACTIVE, write & !TLAST -> ACTIVE; len_acc <= len_next.
  - ACTIVE, write & TLAST -> IDLE; PKT_COUNT += 1; len_acc <= 0.
  - ACTIVE, FULL or oversize -> REVERT this cycle; -> DROP, or IDLE if TLAST. DROP_COUNT += 1. len_acc <= 0.
  - DROP, beat & TLAST -> IDLE.
  - DROP, other beats are ignored.
- No beat: state and len_acc hold. TVALID gaps mid-packet are legal.
- Once a packet enters DROP it is never partially committed, even if FULL deasserts.
- Counters wrap at 2^32.
- Reset values: state IDLE, len_acc 0, PKT_COUNT 0, DROP_COUNT 0. FIFO_WREN, FIFO_COMMIT and FIFO_REVERT are 0 while RST=1. S_AXIS_TREADY=1.
- Reset mid-packet: the block returns to IDLE. Upstream is reset with the same RST, so no trailing beats arrive after reset.

Test Plan:
- 3-beat packet, TKEEP all ones, all ones, 0x0000_00FF, FIFO_FULL=0 -> three FIFO_WREN pulses; FIFO_COMMIT on beat 3 with FIFO_MI=72; PKT_COUNT=1; no REVERT.
- Single-beat packet, TKEEP=0x0000_000F -> WREN and COMMIT in the same cycle; FIFO_MI=4; state stays IDLE.
- 4-beat packet with FIFO_FULL=1 during beat 2 -> beat 1 written; beat 2 gives REVERT=1, WREN=0; beats 3-4 give no WREN even with FULL=0; DROP_COUNT=1; the next packet is written normally.
- FIFO_FULL=1 on the first beat of a 2-beat packet -> no WREN, no REVERT; DROP_COUNT=1; back in IDLE after TLAST.
- MAX_PKT_BYTES=64, 3 full beats -> beats 1-2 written; beat 3 gives REVERT with no COMMIT; DROP_COUNT=1.
- RST asserted in ACTIVE after 2 beats -> WREN, COMMIT and REVERT are 0 during reset; state IDLE; counters 0; a fresh 1-beat packet afterwards commits with the correct FIFO_MI.
